// File: rtl/clk_sched_pkg.sv
// Shared constants and config-FSM state encoding for the clock-enable scheduler.
package clk_sched_pkg;

    localparam int unsigned DIV_W  = 27;
    localparam int unsigned NUM_CH = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cfg_state_e;

endpackage

// File: rtl/clk_en_sched_tick_chan.sv
// One tick channel: free-running divider producing a one-cycle tick and a square-wave level.
module tick_chan #(
    parameter int unsigned DIV_W = clk_sched_pkg::DIV_W
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             sync_i,
    output logic             tick_o,
    output logic             lvl_o
);

    logic             en_q, en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic             lvl_q, lvl_d;

    always_comb begin
        en_d   = en_q;
        div_d  = div_q;
        cnt_d  = cnt_q;
        tick_d = 1'b0;
        if (load_i) begin
            en_d  = en_i;
            div_d = div_i;
            cnt_d = '0;
        end else if (!en_q || (div_q == '0)) begin
            cnt_d = '0;
        end else if (sync_i) begin
            // Phase alignment wins over a coincident wrap, so no tick here.
            cnt_d = '0;
        end else if (cnt_q == div_q - DIV_W'(1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d = cnt_q + DIV_W'(1);
        end
        // Level tracks the count that becomes visible on the same edge.
        lvl_d = en_d && (div_d != '0) && (cnt_d >= (div_d >> 1));
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            en_q   <= 1'b0;
            div_q  <= '0;
            cnt_q  <= '0;
            tick_q <= 1'b0;
            lvl_q  <= 1'b0;
        end else begin
            en_q   <= en_d;
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
            lvl_q  <= lvl_d;
        end
    end

    assign tick_o = tick_q;
    assign lvl_o  = lvl_q;

endmodule

// File: rtl/clk_en_sched.sv
// Clock-enable scheduler: config handshake FSM driving NUM_CH independent tick channels.
module clk_en_sched #(
    parameter int unsigned NUM_CH = clk_sched_pkg::NUM_CH,
    parameter int unsigned DIV_W  = clk_sched_pkg::DIV_W
) (
    input  logic              clkin,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [1:0]        cfg_chan,
    input  logic              cfg_en,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              sync_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] lvl_o,
    output logic              busy_o,
    output logic              err_o
);

    import clk_sched_pkg::cfg_state_e;
    import clk_sched_pkg::IDLE;
    import clk_sched_pkg::APPLY;

    cfg_state_e       state_q, state_d;
    logic [1:0]       chan_q;
    logic             en_q;
    logic [DIV_W-1:0] div_q;
    logic             err_q;
    logic             hs;
    logic             apply;
    logic             chan_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (cfg_valid) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign cfg_ready = (state_q == IDLE);
    assign busy_o    = (state_q == APPLY);
    assign hs        = cfg_valid && cfg_ready;
    assign apply     = busy_o;
    assign chan_ok   = 32'(chan_q) < NUM_CH;
    assign err_o     = err_q;

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q <= IDLE;
            chan_q  <= '0;
            en_q    <= 1'b0;
            div_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= apply && !chan_ok;
            if (hs) begin
                chan_q <= cfg_chan;
                en_q   <= cfg_en;
                div_q  <= cfg_div;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        tick_chan #(
            .DIV_W(DIV_W)
        ) u_chan (
            .clkin  (clkin),
            .rst    (rst),
            .load_i (apply && (32'(chan_q) == i)),
            .en_i   (en_q),
            .div_i  (div_q),
            .sync_i (sync_i),
            .tick_o (tick_o[i]),
            .lvl_o  (lvl_o[i])
        );
    end

endmodule
